// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - binary16 constants, rounding modes and divider state encoding shared by the FP datapath
package fp16_pkg;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RP  = 2'b10,
    RN  = 2'b11
  } roundmode_t;

  localparam int          FP16_BIAS = 15;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_MAXF = 16'h7BFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ROUND,
    S_DONE
  } div_state_t;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam int DIV_STEPS = 14;

endpackage

// File: rtl/fp16_round.sv
// rtl/fp16_round.sv - combinational binary16 round/pack stage shared by fp16_div and fma16
module fp16_round
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic signed [6:0] exp_in,
  input  logic [10:0]       mant,
  input  logic              guard,
  input  logic              sticky,
  input  roundmode_t        roundmode,
  output logic [15:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  logic              lost;
  logic              round_up;
  logic [10:0]       frac_sum;
  logic              carry;
  logic signed [6:0] exp_n;

  always_comb begin
    lost     = guard | sticky;
    round_up = 1'b0;
    case (roundmode)
      RZ:  round_up = 1'b0;
      RNE: round_up = guard & (sticky | mant[0]);
      RP:  round_up = lost & ~sign;
      RN:  round_up = lost & sign;
    endcase

    // A carry out of the fraction wraps it to zero, which is exactly mantissa 1024 with exp+1
    frac_sum = {1'b0, mant[9:0]} + {10'b0, round_up};
    carry    = frac_sum[10];
    exp_n    = exp_in + (carry ? 7'sd1 : 7'sd0);

    overflow  = (exp_n >= 7'sd31);
    underflow = (exp_n <= 7'sd0);
    inexact   = lost | overflow | underflow;
    result    = {sign, exp_n[4:0], frac_sum[9:0]};

    if (!mant[10]) begin
      // No hidden bit means an exact zero (e.g. cancellation in fma16)
      overflow  = 1'b0;
      underflow = 1'b0;
      inexact   = 1'b0;
      result    = {sign, 15'b0};
    end else if (overflow) begin
      case (roundmode)
        RZ:  result = {sign, FP16_MAXF[14:0]};
        RNE: result = {sign, FP16_INF[14:0]};
        RP:  result = sign ? {1'b1, FP16_MAXF[14:0]} : FP16_INF;
        RN:  result = sign ? {1'b1, FP16_INF[14:0]} : FP16_MAXF;
      endcase
    end else if (underflow) begin
      result = {sign, 15'b0};
    end
  end

endmodule

// File: rtl/fp16_div.sv
// rtl/fp16_div.sv - sequential binary16 divider, radix-2 restoring, valid/ready in and out
module fp16_div
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  roundmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [4:0]  flags
);

  div_state_t        state, state_next;
  logic [3:0]        cnt;
  logic [12:0]       rem;
  logic [10:0]       dvs;
  logic [13:0]       q;
  logic              sign_r;
  logic signed [6:0] exp_r;
  roundmode_t        rm_r;
  logic [15:0]       result_r;
  logic [4:0]        flags_r;

  logic [4:0]  ex, ey;
  logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  logic        q_sign;
  logic        spec_hit;
  logic [15:0] spec_result;
  logic [4:0]  spec_flags;

  logic        rem_ge;
  logic [12:0] rem_diff;

  logic              rnd_sign;
  logic signed [6:0] rnd_exp;
  logic [10:0]       rnd_mant;
  logic              rnd_guard, rnd_sticky;
  logic [15:0]       rnd_result;
  logic              rnd_ovf, rnd_unf, rnd_inx;

  assign ex     = x[14:10];
  assign ey     = y[14:10];
  assign x_nan  = (&ex) & (|x[9:0]);
  assign y_nan  = (&ey) & (|y[9:0]);
  assign x_inf  = (&ex) & ~(|x[9:0]);
  assign y_inf  = (&ey) & ~(|y[9:0]);
  assign x_zero = ~(|ex);
  assign y_zero = ~(|ey);
  assign q_sign = x[15] ^ y[15];

  always_comb begin
    spec_hit    = 1'b1;
    spec_result = 16'h0000;
    spec_flags  = 5'b0;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_result               = FP16_QNAN;
      spec_flags[FLAG_INVALID]  = 1'b1;
    end else if (x_inf) begin
      spec_result = {q_sign, FP16_INF[14:0]};
    end else if (y_inf) begin
      spec_result = {q_sign, 15'b0};
    end else if (y_zero) begin
      spec_result               = {q_sign, FP16_INF[14:0]};
      spec_flags[FLAG_DIVZERO]  = 1'b1;
    end else if (x_zero) begin
      spec_result = {q_sign, 15'b0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = spec_hit ? S_DONE : S_DIV;
      S_DIV:   if (cnt == 4'(DIV_STEPS - 1)) state_next = S_ROUND;
      S_ROUND: state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  assign rem_ge   = (rem >= {2'b00, dvs});
  assign rem_diff = rem_ge ? (rem - {2'b00, dvs}) : rem;

  // Quotient below 1 leaves q[13] clear; shift one more bit into the mantissa
  assign rnd_sign   = sign_r;
  assign rnd_mant   = q[13] ? q[13:3] : q[12:2];
  assign rnd_guard  = q[13] ? q[2] : q[1];
  assign rnd_sticky = (q[13] ? (|q[1:0]) : q[0]) | (|rem);
  assign rnd_exp    = exp_r - (q[13] ? 7'sd0 : 7'sd1);

  fp16_round u_round (
    .sign      (rnd_sign),
    .exp_in    (rnd_exp),
    .mant      (rnd_mant),
    .guard     (rnd_guard),
    .sticky    (rnd_sticky),
    .roundmode (rm_r),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf),
    .inexact   (rnd_inx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt      <= 4'd0;
      rem      <= 13'd0;
      dvs      <= 11'd0;
      q        <= 14'd0;
      sign_r   <= 1'b0;
      exp_r    <= 7'sd0;
      rm_r     <= RZ;
      result_r <= 16'h0000;
      flags_r  <= 5'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            rm_r   <= roundmode_t'(roundmode);
            sign_r <= q_sign;
            cnt    <= 4'd0;
            q      <= 14'd0;
            rem    <= {2'b00, 1'b1, x[9:0]};
            dvs    <= {1'b1, y[9:0]};
            exp_r  <= {2'b00, ex} - {2'b00, ey} + 7'(FP16_BIAS);
            if (spec_hit) begin
              result_r <= spec_result;
              flags_r  <= spec_flags;
            end
          end
        end
        S_DIV: begin
          q   <= {q[12:0], rem_ge};
          rem <= rem_diff << 1;
          cnt <= cnt + 4'd1;
        end
        S_ROUND: begin
          result_r <= rnd_result;
          flags_r  <= {2'b00, rnd_ovf, rnd_unf, rnd_inx};
        end
        S_DONE: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_fp16_div.sv
// tb/tb_fp16_div.sv - self-checking bench for fp16_div: directed vectors, random vs reference, backpressure, reset
module tb_fp16_div;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  fp16_div dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .roundmode (roundmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  rm;
    logic [15:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact quotient of the significands, correctly rounded to 11 bits
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                                  output logic [15:0] r, output logic [4:0] f, output bit sp);
    int ea, eb, fa, fb, e;
    longint mx, my, num, qv, rmd, mant;
    bit sgn, na, nb, ia, ib, za, zb, g, st, up;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    sgn = a[15] ^ b[15];
    na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
    ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
    za = (ea == 0);               zb = (eb == 0);
    sp = 1'b1;
    f  = 5'b0;
    if (na || nb || (za && zb) || (ia && ib)) begin r = 16'h7E00; f = 5'b10000; return; end
    if (ia) begin r = {sgn, 15'h7C00}; return; end
    if (ib) begin r = {sgn, 15'h0000}; return; end
    if (zb) begin r = {sgn, 15'h7C00}; f = 5'b01000; return; end
    if (za) begin r = {sgn, 15'h0000}; return; end
    sp = 1'b0;
    mx = 1024 + fa;
    my = 1024 + fb;
    if (mx >= my) begin num = mx * 4096; e = ea - eb + 15; end
    else          begin num = mx * 8192; e = ea - eb + 14; end
    qv   = num / my;
    rmd  = num % my;
    mant = qv / 4;
    g    = ((qv / 2) % 2) == 1;
    st   = ((qv % 2) == 1) || (rmd != 0);
    case (rm)
      2'd0: up = 1'b0;
      2'd1: up = g && (st || (mant % 2 == 1));
      2'd2: up = (g || st) && !sgn;
      default: up = (g || st) && sgn;
    endcase
    mant = mant + (up ? 1 : 0);
    if (mant == 2048) begin mant = 1024; e = e + 1; end
    if (e >= 31) begin
      f = 5'b00101;
      case (rm)
        2'd0: r = {sgn, 15'h7BFF};
        2'd1: r = {sgn, 15'h7C00};
        2'd2: r = sgn ? 16'hFBFF : 16'h7C00;
        default: r = sgn ? 16'hFC00 : 16'h7BFF;
      endcase
    end else if (e <= 0) begin
      f = 5'b00011;
      r = {sgn, 15'h0000};
    end else begin
      f = {4'b0, g || st};
      r = {sgn, 5'(e), 10'(mant - 1024)};
    end
  endfunction

  // Called at a negedge; returns at the first negedge after the accept edge
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1");
    end
    x = a; y = b; roundmode = rm; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic collect(output logic [15:0] r, output logic [4:0] f, output int n);
    wait_valid(n);
    r = result;
    f = flags;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r, hold, a, b, er;
    logic [4:0]  f, ef;
    logic [1:0]  rm;
    bit          sp;
    int          n, seen;

    in_valid = 1'b0; out_ready = 1'b0; x = 16'h0; y = 16'h0; roundmode = 2'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'h0);
    check("reset_flags", 32'(flags), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{16'h3C00, 16'h3C00, 2'b01, 16'h3C00, 5'b00000, 16});
    vecs.push_back('{16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'b00001, 16});
    vecs.push_back('{16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'b00001, 16});
    vecs.push_back('{16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'b00001, 16});
    vecs.push_back('{16'h3C00, 16'h4200, 2'b11, 16'h3555, 5'b00001, 16});
    vecs.push_back('{16'h4000, 16'h0000, 2'b01, 16'h7C00, 5'b01000, 1});
    vecs.push_back('{16'h0000, 16'h0000, 2'b01, 16'h7E00, 5'b10000, 1});
    vecs.push_back('{16'hFC00, 16'h4000, 2'b01, 16'hFC00, 5'b00000, 1});
    vecs.push_back('{16'h3C00, 16'h7C00, 2'b01, 16'h0000, 5'b00000, 1});
    vecs.push_back('{16'h7BFF, 16'h1400, 2'b01, 16'h7C00, 5'b00101, 16});
    vecs.push_back('{16'h7BFF, 16'h1400, 2'b00, 16'h7BFF, 5'b00101, 16});
    vecs.push_back('{16'h0400, 16'h7800, 2'b01, 16'h0000, 5'b00011, 16});
    vecs.push_back('{16'h4400, 16'h4000, 2'b01, 16'h4000, 5'b00000, 16});

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].rm);
      collect(r, f, n);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].fl));
      check($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      check($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
    end

    for (int i = 0; i < 300; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a[14:10] = 5'($urandom_range(1, 30));
      if ($urandom_range(0, 3) != 0) b[14:10] = 5'($urandom_range(1, 30));
      ref_div(a, b, rm, er, ef, sp);
      issue(a, b, rm);
      collect(r, f, n);
      check($sformatf("rand%0d_%h_%h_rm%0d_result", i, a, b, rm), 32'(r), 32'(er));
      check($sformatf("rand%0d_%h_%h_rm%0d_flags", i, a, b, rm), 32'(f), 32'(ef));
      check($sformatf("rand%0d_latency", i), 32'(n), sp ? 32'd1 : 32'd16);
    end

    // Backpressure: result frozen, in_valid ignored while DONE
    issue(16'h3C00, 16'h4200, 2'b01);
    wait_valid(n);
    hold = result;
    check("bp_first_result", 32'(hold), 32'h3555);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin x = 16'h4400; y = 16'h4000; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("bp%0d_result", i), 32'(result), 32'(hold));
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_pulse_ignored", 32'(out_valid), 32'd0);

    // Reset in the middle of the iteration
    issue(16'h3C00, 16'h4200, 2'b01);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_stale_valid", 32'(seen), 32'd0);
    issue(16'h4400, 16'h4000, 2'b01);
    collect(r, f, n);
    check("rst_new_result", 32'(r), 32'h4000);
    check("rst_new_flags", 32'(f), 32'h0);
    check("rst_new_latency", 32'(n), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
